// File: rtl/cache_tag_ctrl_if.sv
// Lookup, flush and refill handshake bundle for cache_tag_ctrl.
// The master side issues requests and answers refills; the slave side is the tag controller.
interface cache_tag_ctrl_if #(
   parameter int TAG_W = 36,
   parameter int WAYS  = 4,
   parameter int IDX_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic             flush;
   logic             flush_busy;
   logic             resp_valid;
   logic             resp_hit;
   logic [WAYS-1:0]  resp_way;
   logic             fill_req;
   logic [WAYS-1:0]  fill_way;
   logic             fill_done;

   modport master (
      output req_valid, req_tag, req_idx, flush, fill_done,
      input  req_ready, flush_busy, resp_valid, resp_hit, resp_way, fill_req, fill_way
   );

   modport slave (
      input  req_valid, req_tag, req_idx, flush, fill_done,
      output req_ready, flush_busy, resp_valid, resp_hit, resp_way, fill_req, fill_way
   );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Set-associative tag controller: lookup with age-based replacement, refill handshake,
// and a one-set-per-cycle invalidate sweep.
module cache_tag_ctrl #(
   parameter int TAG_W = 36,
   parameter int WAYS  = 4,
   parameter int IDX_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   cache_tag_ctrl_if.slave bus
);
   localparam int SETS  = 1 << IDX_W;
   localparam int AGE_W = $clog2(WAYS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      FILL   = 3'd2,
      RESP   = 3'd3,
      FLUSH  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [TAG_W-1:0] tag_d   [SETS][WAYS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  valid_d [SETS];
   logic [AGE_W-1:0] age_q   [SETS][WAYS];
   logic [AGE_W-1:0] age_d   [SETS][WAYS];
   logic [TAG_W-1:0] lk_tag_q, lk_tag_d;
   logic [IDX_W-1:0] lk_idx_q, lk_idx_d;
   logic [IDX_W-1:0] fcnt_q, fcnt_d;
   logic [WAYS-1:0]  way_q, way_d;
   logic             hit_q, hit_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_hit_q, resp_hit_d;
   logic [WAYS-1:0]  resp_way_q, resp_way_d;

   logic [WAYS-1:0]  hit_oh;
   logic [WAYS-1:0]  inv_oh;
   logic [WAYS-1:0]  old_oh;
   logic [WAYS-1:0]  victim_oh;
   logic [WAYS-1:0]  touch_oh;
   logic             touch_en;
   logic [AGE_W-1:0] touch_age;

   function automatic logic [AGE_W-1:0] oh_to_idx(input logic [WAYS-1:0] oh);
      logic [AGE_W-1:0] idx;
      idx = {AGE_W{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
         idx = idx | (oh[w] ? AGE_W'(w) : {AGE_W{1'b0}});
      end
      return idx;
   endfunction

   // Accessed way becomes youngest; ways younger than it age by one.
   function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] cur,
                                                 input logic [AGE_W-1:0] acc_age,
                                                 input logic             is_acc);
      logic [AGE_W-1:0] nxt;
      if (is_acc) begin
         nxt = {AGE_W{1'b0}};
      end else if (cur < acc_age) begin
         nxt = cur + AGE_W'(1'b1);
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction

   // Hit and victim selection for the latched set, each reduced to the lowest-index way.
   always_comb begin
      hit_oh = {WAYS{1'b0}};
      inv_oh = {WAYS{1'b0}};
      old_oh = {WAYS{1'b0}};
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[lk_idx_q][w] && (tag_q[lk_idx_q][w] == lk_tag_q)) begin
            hit_oh = WAYS'(1'b1) << w;
         end else begin
            hit_oh = hit_oh;
         end
         if (!valid_q[lk_idx_q][w]) begin
            inv_oh = WAYS'(1'b1) << w;
         end else begin
            inv_oh = inv_oh;
         end
         if (age_q[lk_idx_q][w] == AGE_W'(WAYS - 1)) begin
            old_oh = WAYS'(1'b1) << w;
         end else begin
            old_oh = old_oh;
         end
      end
      if (|inv_oh) begin
         victim_oh = inv_oh;
      end else if (|old_oh) begin
         victim_oh = old_oh;
      end else begin
         victim_oh = WAYS'(1'b1);
      end
   end

   // Next-state, array updates and response staging.
   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      valid_d      = valid_q;
      age_d        = age_q;
      lk_tag_d     = lk_tag_q;
      lk_idx_d     = lk_idx_q;
      fcnt_d       = fcnt_q;
      way_d        = way_q;
      hit_d        = hit_q;
      resp_valid_d = 1'b0;
      resp_hit_d   = 1'b0;
      resp_way_d   = {WAYS{1'b0}};
      touch_en     = 1'b0;
      touch_oh     = {WAYS{1'b0}};
      touch_age    = {AGE_W{1'b0}};

      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               state_d = FLUSH;
               fcnt_d  = {IDX_W{1'b0}};
            end else if (bus.req_valid) begin
               lk_tag_d = bus.req_tag;
               lk_idx_d = bus.req_idx;
               state_d  = LOOKUP;
            end else begin
               state_d = IDLE;
            end
         end
         LOOKUP: begin
            if (|hit_oh) begin
               hit_d    = 1'b1;
               way_d    = hit_oh;
               touch_en = 1'b1;
               touch_oh = hit_oh;
               state_d  = RESP;
            end else begin
               hit_d   = 1'b0;
               way_d   = victim_oh;
               state_d = FILL;
            end
         end
         FILL: begin
            if (bus.fill_done) begin
               tag_d[lk_idx_q][oh_to_idx(way_q)] = lk_tag_q;
               valid_d[lk_idx_q] = valid_q[lk_idx_q] | way_q;
               touch_en = 1'b1;
               touch_oh = way_q;
               state_d  = RESP;
            end else begin
               state_d = FILL;
            end
         end
         RESP: begin
            resp_valid_d = 1'b1;
            resp_hit_d   = hit_q;
            resp_way_d   = way_q;
            state_d      = IDLE;
         end
         FLUSH: begin
            valid_d[fcnt_q] = {WAYS{1'b0}};
            if (fcnt_q == IDX_W'(SETS - 1)) begin
               state_d = IDLE;
            end else begin
               fcnt_d = fcnt_q + IDX_W'(1'b1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (touch_en) begin
         touch_age = age_q[lk_idx_q][oh_to_idx(touch_oh)];
         for (int w = 0; w < WAYS; w++) begin
            age_d[lk_idx_q][w] = age_next(age_q[lk_idx_q][w], touch_age, touch_oh[w]);
         end
      end else begin
         touch_age = {AGE_W{1'b0}};
      end
   end

   // State registers; reset aborts any sweep or refill before its tag write lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= {WAYS{1'b0}};
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= AGE_W'(w);
            end
         end
         lk_tag_q     <= {TAG_W{1'b0}};
         lk_idx_q     <= {IDX_W{1'b0}};
         fcnt_q       <= {IDX_W{1'b0}};
         way_q        <= {WAYS{1'b0}};
         hit_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_way_q   <= {WAYS{1'b0}};
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         valid_q      <= valid_d;
         age_q        <= age_d;
         lk_tag_q     <= lk_tag_d;
         lk_idx_q     <= lk_idx_d;
         fcnt_q       <= fcnt_d;
         way_q        <= way_d;
         hit_q        <= hit_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_way_q   <= resp_way_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE) & ~bus.flush & ~rst;
   assign bus.flush_busy = (state_q == FLUSH);
   assign bus.fill_req   = (state_q == FILL);
   assign bus.fill_way   = (state_q == FILL) ? way_q : {WAYS{1'b0}};
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_hit   = resp_hit_q;
   assign bus.resp_way   = resp_way_q;
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl with a recency-list cache model and a per-cycle
// response/refill scoreboard.
module tb_cache_tag_ctrl;
   localparam int TAG_W = 36;
   localparam int WAYS  = 4;
   localparam int IDX_W = 4;
   localparam int SETS  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   cache_tag_ctrl_if #(.TAG_W(TAG_W), .WAYS(WAYS), .IDX_W(IDX_W)) bus ();

   cache_tag_ctrl #(.TAG_W(TAG_W), .WAYS(WAYS), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       hit;
      logic [3:0] way;
      int         cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  exp_fill_way = 4'b0000;
   bit          flush_ok = 1'b0;
   logic        last_hit = 1'b0;
   logic [3:0]  last_way = 4'b0000;
   logic [3:0]  last_fill_way = 4'b0000;

   // Cache model: valid/tag per way, plus a recency list per set (front = most recent).
   bit          m_valid [SETS][WAYS];
   logic [35:0] m_tag   [SETS][WAYS];
   int          m_order [SETS][$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void m_reset();
      for (int s = 0; s < SETS; s++) begin
         m_order[s].delete();
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_order[s].push_back(w);
         end
      end
   endfunction

   function automatic void m_flush();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            m_valid[s][w] = 1'b0;
   endfunction

   function automatic void m_touch(input int s, input int w);
      for (int i = m_order[s].size() - 1; i >= 0; i--)
         if (m_order[s][i] == w) m_order[s].delete(i);
      m_order[s].push_front(w);
   endfunction

   function automatic void m_fill(input logic [35:0] t, input int s, input int w);
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = t;
      m_touch(s, w);
   endfunction

   function automatic void m_predict(input logic [35:0] t, input int s, output bit h, output int w);
      h = 1'b0;
      w = -1;
      for (int i = 0; i < WAYS; i++)
         if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) begin
            h = 1'b1;
            w = i;
         end
      if (!h) begin
         for (int i = 0; i < WAYS; i++)
            if (w < 0 && !m_valid[s][i]) w = i;
         if (w < 0) w = m_order[s][WAYS-1];
      end
   endfunction

   // Per-cycle compare of responses, refill way and busy flags against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.resp_valid) begin
            last_hit = bus.resp_hit;
            last_way = bus.resp_way;
            if (exp_q.size() == 0) begin
               check("resp_unexpected", {63'd0, bus.resp_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("resp_hit", {63'd0, bus.resp_hit}, {63'd0, e.hit});
               check("resp_way", {60'd0, bus.resp_way}, {60'd0, e.way});
               check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (bus.fill_req) begin
            last_fill_way = bus.fill_way;
            check("fill_way", {60'd0, bus.fill_way}, {60'd0, exp_fill_way});
         end
         if (bus.flush_busy && !flush_ok)
            check("flush_busy_unexpected", {63'd0, bus.flush_busy}, 64'd0);
         if (bus.req_ready && (bus.flush_busy || bus.fill_req))
            check("req_ready_while_busy", {63'd0, bus.req_ready}, 64'd0);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      bus.fill_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready",  {63'd0, bus.req_ready},  64'd0);
      check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      check("rst_resp_hit",   {63'd0, bus.resp_hit},   64'd0);
      check("rst_resp_way",   {60'd0, bus.resp_way},   64'd0);
      check("rst_fill_req",   {63'd0, bus.fill_req},   64'd0);
      check("rst_fill_way",   {60'd0, bus.fill_way},   64'd0);
      check("rst_flush_busy", {63'd0, bus.flush_busy}, 64'd0);
      rst = 1'b0;
      m_reset();
      exp_q.delete();
      exp_fill_way = 4'b0000;
      @(negedge clk);
      check("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);
   endtask

   // mode 0: plain access; mode 1: flush pulse inside FILL; mode 2: reset inside FILL.
   task automatic request(input logic [35:0] tag, input int idx, input int dly, input int mode);
      bit   h;
      int   w;
      int   t;
      exp_t e;
      m_predict(tag, idx, h, w);
      exp_fill_way = h ? 4'b0000 : 4'(1 << w);
      t = 0;
      while (bus.req_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("req_ready_timeout", {63'd0, bus.req_ready}, 64'd1);
      bus.req_valid = 1'b1;
      bus.req_tag   = tag;
      bus.req_idx   = 4'(idx);
      if (h) begin
         e.hit = 1'b1;
         e.way = 4'(1 << w);
         e.cyc = cyc + 3;
         exp_q.push_back(e);
         m_touch(idx, w);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (!h) begin
         t = 0;
         while (!bus.fill_req && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (t >= 20) check("fill_req_timeout", {63'd0, bus.fill_req}, 64'd1);
         if (mode == 2) begin
            rst = 1'b1;
            @(negedge clk);
            check("fill_req_after_rst",  {63'd0, bus.fill_req},   64'd0);
            check("resp_valid_in_rst",   {63'd0, bus.resp_valid}, 64'd0);
            rst = 1'b0;
            m_reset();
            exp_fill_way = 4'b0000;
            return;
         end
         if (mode == 1) begin
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            check("fill_held_after_flush", {63'd0, bus.fill_req}, 64'd1);
         end
         repeat (dly) @(negedge clk);
         bus.fill_done = 1'b1;
         e.hit = 1'b0;
         e.way = 4'(1 << w);
         e.cyc = cyc + 2;
         exp_q.push_back(e);
         m_fill(tag, idx, w);
         @(negedge clk);
         bus.fill_done = 1'b0;
      end
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         check("resp_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      exp_fill_way = 4'b0000;
   endtask

   task automatic do_flush(input bit with_req);
      int n;
      flush_ok  = 1'b1;
      bus.flush = 1'b1;
      if (with_req) begin
         bus.req_valid = 1'b1;
         bus.req_tag   = 36'h5;
         bus.req_idx   = 4'd3;
      end
      @(negedge clk);
      bus.flush = 1'b0;
      n = 0;
      while (bus.flush_busy && n < 40) begin
         if (with_req) check("req_ready_during_flush", {63'd0, bus.req_ready}, 64'd0);
         n++;
         @(negedge clk);
      end
      check("flush_busy_cycles", 64'(n), 64'd16);
      m_flush();
      flush_ok = 1'b0;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_tag   = 36'h0;
      bus.req_idx   = 4'd0;
      bus.flush     = 1'b0;
      bus.fill_done = 1'b0;
      m_reset();

      do_reset();
      request(36'h5, 3, 2, 0);
      check("l042_hit",       {63'd0, last_hit},      64'd0);
      check("l042_way",       {60'd0, last_way},      64'h1);
      check("l042_fill_way",  {60'd0, last_fill_way}, 64'h1);
      request(36'h5, 3, 0, 0);
      check("l043_hit",       {63'd0, last_hit},      64'd1);
      check("l043_way",       {60'd0, last_way},      64'h1);

      do_reset();
      request(36'hA, 3, 1, 0);
      request(36'hB, 3, 1, 0);
      request(36'hC, 3, 1, 0);
      request(36'hD, 3, 1, 0);
      request(36'hA, 3, 0, 0);
      check("l044_hit_a",     {63'd0, last_hit},      64'd1);
      check("l044_way_a",     {60'd0, last_way},      64'h1);
      request(36'hE, 3, 1, 0);
      check("l044_fill_way",  {60'd0, last_fill_way}, 64'h2);
      check("l044_way_e",     {60'd0, last_way},      64'h2);

      request(36'h77, 5, 2, 1);
      check("l045_fill_hit",  {63'd0, last_hit},      64'd0);
      do_flush(1'b0);
      request(36'hD, 3, 1, 0);
      check("l045_d_hit",     {63'd0, last_hit},      64'd0);
      check("l045_d_way",     {60'd0, last_way},      64'h1);
      request(36'hA, 3, 1, 0);
      check("l045_a_hit",     {63'd0, last_hit},      64'd0);
      check("l045_a_way",     {60'd0, last_way},      64'h2);
      request(36'h77, 5, 1, 0);
      check("l045_77_hit",    {63'd0, last_hit},      64'd0);

      request(36'h99, 2, 1, 2);
      request(36'h99, 2, 1, 0);
      check("l046_hit",       {63'd0, last_hit},      64'd0);
      check("l046_way",       {60'd0, last_way},      64'h1);

      do_flush(1'b1);
      request(36'h5, 3, 1, 0);
      check("l047_hit",       {63'd0, last_hit},      64'd0);
      check("l047_way",       {60'd0, last_way},      64'h1);
      request(36'h5, 3, 0, 0);
      check("l047_rehit",     {63'd0, last_hit},      64'd1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
